// File: rtl/key_conditioner_pkg.sv
// Shared definitions for the key conditioner and the game FSM colour decode.
// FSM state encodings and the one-hot key codes.
package key_conditioner_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_e;

   localparam logic [3:0] KEY_NONE   = 4'h0;
   localparam logic [3:0] KEY_GREEN  = 4'h1;
   localparam logic [3:0] KEY_RED    = 4'h2;
   localparam logic [3:0] KEY_BLUE   = 4'h4;
   localparam logic [3:0] KEY_YELLOW = 4'h8;

endpackage

// File: rtl/sync_nbit.sv
// WIDTH x STAGES flip-flop synchroniser with an asynchronous reset to RESET_VAL.
module sync_nbit #(
   parameter int               WIDTH     = 1,
   parameter int               STAGES    = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clock,
   input  logic             resetApp,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [STAGES];

   // NOTE: every stage is reset to the idle pin level so that leaving reset
   // can never look like an edge; non-blocking assignments keep the chain a shift.
   always_ff @(posedge clock or posedge resetApp) begin
      if (resetApp) begin
         for (int i = 0; i < STAGES; i++) stage_q[i] <= RESET_VAL;
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/key_conditioner.sv
// Synchronises, debounces and chord-filters the active-low buttons into a one-hot key
// with press/release pulses. Build with KEY_REPEAT_EN defined to add auto-repeat.
module key_conditioner
   import key_conditioner_pkg::*;
#(
   parameter int NUM_KEYS        = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000
`ifdef KEY_REPEAT_EN
   ,
   parameter int REPEAT_CYCLES   = 25000000
`endif
) (
   input  logic                clock,
   input  logic                resetApp,
   input  logic [NUM_KEYS-1:0] n_key,
   output logic [NUM_KEYS-1:0] key,
   output logic                keyValid,
   output logic                keyPress,
   output logic                keyRelease
);

   localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_KEYS-1:0] n_key_sync;
   logic [NUM_KEYS-1:0] s;
   logic                s_valid;

   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [NUM_KEYS-1:0] cand_q;
   logic [NUM_KEYS-1:0] key_q;
   logic                press_q;
   logic                release_q;

   sync_nbit #(
      .WIDTH     (NUM_KEYS),
      .STAGES    (SYNC_STAGES),
      .RESET_VAL ({NUM_KEYS{1'b1}})
   ) u_sync (
      .clock    (clock),
      .resetApp (resetApp),
      .d_i      (n_key),
      .q_o      (n_key_sync)
   );

   assign s       = ~n_key_sync;
   assign s_valid = $onehot(s);

`ifdef KEY_REPEAT_EN
   localparam int             REP_W    = $clog2(REPEAT_CYCLES);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
   logic [REP_W-1:0] rep_q;
`endif

   always_ff @(posedge clock or posedge resetApp) begin
      if (resetApp) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         cand_q    <= '0;
         key_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
`ifdef KEY_REPEAT_EN
         rep_q     <= '0;
`endif
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (s_valid) begin
                  state_q <= PRESS_WAIT;
                  cand_q  <= s;
                  cnt_q   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!s_valid) begin
                  state_q <= IDLE;
               end else if (s != cand_q) begin
                  cand_q <= s;
                  cnt_q  <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= HELD;
                  key_q   <= cand_q;
                  press_q <= 1'b1;
`ifdef KEY_REPEAT_EN
                  rep_q   <= '0;
`endif
               end else if (cnt_q != '1) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            HELD: begin
               // Any departure from the held code, including an added key, starts a release.
               if (s != key_q) begin
                  state_q <= RELEASE_WAIT;
                  cnt_q   <= '0;
               end
`ifdef KEY_REPEAT_EN
               else if (rep_q == REP_LAST) begin
                  rep_q   <= '0;
                  press_q <= 1'b1;
               end else begin
                  rep_q <= rep_q + 1'b1;
               end
`endif
            end
            RELEASE_WAIT: begin
               if (s == key_q) begin
                  state_q <= HELD;
               end else if (cnt_q == CNT_LAST) begin
                  state_q   <= IDLE;
                  key_q     <= '0;
                  release_q <= 1'b1;
               end else if (cnt_q != '1) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign key        = key_q;
   assign keyValid   = |key_q;
   assign keyPress   = press_q;
   assign keyRelease = release_q;

endmodule
